// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer and its sub-modules.
// The bit-counter width helper is intended for reuse by the matching deserializer.
package word_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Counter width needed to index the bits of a word of the given width.
   function automatic int cw(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/word_serializer_mod_counter.sv
// Bit-position counter for the serializer: counts enabled strobes up to MAX.
// Clear has priority over enable; at_max flags the final position.
module word_serializer_mod_counter
   import word_serializer_pkg::*;
#(
   parameter int MAX = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic at_max
);

   localparam int CW = cw(MAX + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer for gapless streaming.
// Drives a downstream shift register through ser_out/ser_en.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             hold,
   output logic             ser_out,
   output logic             ser_en,
   output logic             word_last,
   output logic             busy
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] hb;
   logic             hb_valid;
   logic             at_max;
   logic             transfer;
   logic             load_in;
   logic             load_hb;
   logic             hb_wr;
   logic             cnt_en;

   // Move the next bit into the emitting position, zero fill behind it.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   assign in_ready  = reset & ~hb_valid;
   assign transfer  = in_valid & in_ready;
   assign ser_en    = (state == ST_SHIFT) & ~hold;
   assign word_last = ser_en & at_max;
   assign cnt_en    = ser_en & ~at_max;
   assign busy      = (state == ST_SHIFT) | hb_valid;
   assign ser_out   = (state == ST_SHIFT) & (LSB_FIRST ? sr[0] : sr[WIDTH-1]);

   word_serializer_mod_counter #(
      .MAX (WIDTH - 1)
   ) u_counter (
      .clk    (clk),
      .reset  (reset),
      .enable (cnt_en),
      .clear  (word_last),
      .at_max (at_max)
   );

   // On the last bit the buffered word wins over a fresh transfer; with
   // nothing waiting, an incoming word bypasses the buffer straight into sr.
   always_comb begin
      state_next = state;
      load_in    = 1'b0;
      load_hb    = 1'b0;
      hb_wr      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (transfer) begin
               load_in    = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (word_last) begin
               if (hb_valid) begin
                  load_hb = 1'b1;
               end else if (transfer) begin
                  load_in = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end else if (transfer) begin
               hb_wr = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sr <= '0;
      end else if (load_in) begin
         sr <= in_data;
      end else if (load_hb) begin
         sr <= hb;
      end else if (cnt_en) begin
         sr <= shift_word(sr);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hb_valid <= 1'b0;
      end else if (load_hb) begin
         hb_valid <= 1'b0;
      end else if (hb_wr) begin
         hb_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (hb_wr) begin
         hb <= in_data;
      end
   end

endmodule
